mandel_pixel_writer: RTL and testbench

- Consumer end of the Mandelbrot iterator array. Accepts per-pixel escape counts from PARTITION iterator lanes over valid/ready.
- Maps each count to an 8-bit RGB332 colour and derives the pixel's frame-buffer address from lane-owned column interleave.
- Writes pixels to VGA pixel memory through a req/ack write port and raises done when the full frame is written.

---
 rtl/mandel_pkg.sv | 13 +
 rtl/mandel_color_map.sv | 19 +
 rtl/mandel_pixel_writer.sv | 168 ++++++++++++++++
 tb/tb_mandel_pixel_writer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandel_pkg.sv
// Shared definitions for the Mandelbrot pixel path: FSM encodings, widths and the in-set colour.
package mandel_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int COUNT_W = 11;
  localparam int COLOR_W = 8;

  localparam logic [COLOR_W-1:0] IN_SET_COLOR = 8'h00;

endpackage

// File: rtl/mandel_color_map.sv
// Combinational escape-count to RGB332 colour; zero latency, no flow control.
module mandel_color_map
  import mandel_pkg::*;
#(
  parameter int MAX_ITERATIONS = 100
) (
  input  logic [COUNT_W-1:0] count_i,
  output logic [COLOR_W-1:0] color_o
);

  always_comb begin
    if (count_i >= COUNT_W'(MAX_ITERATIONS)) begin
      color_o = IN_SET_COLOR;
    end else begin
      color_o = ~count_i[COLOR_W-1:0];
    end
  end

endmodule

// File: rtl/mandel_pixel_writer.sv
// Collects per-lane escape counts, writes coloured pixels one per 2 cycles (req 1 cycle after capture), holds in_ready low while a lane's register is full.
// Optional MANDEL_PERF_CNT_EN adds a saturating 32-bit RUN-cycle counter on port cycles.
module mandel_pixel_writer
  import mandel_pkg::*;
#(
  parameter int PARTITION      = 2,
  parameter int MAX_ITERATIONS = 100,
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int ADDR_W         = 19
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [PARTITION-1:0]           in_valid,
  input  logic [PARTITION*COUNT_W-1:0]   in_count,
  output logic [PARTITION-1:0]           in_ready,
  output logic                           mem_req,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [COLOR_W-1:0]             mem_data,
  input  logic                           mem_ack,
  output logic                           done
`ifdef MANDEL_PERF_CNT_EN
  ,
  output logic [31:0]                    cycles
`endif
);

  localparam int LANE_W = (PARTITION > 1) ? $clog2(PARTITION) : 1;
  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(SCREEN_W / PARTITION - 1);
  localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(SCREEN_H - 1);
  localparam logic [ADDR_W-1:0] W_STEP = ADDR_W'(SCREEN_W);
  localparam logic [ADDR_W-1:0] P_STEP = ADDR_W'(PARTITION);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

  logic [1:0]           state_q, state_d;
  logic [COUNT_W-1:0]   cnt_q  [PARTITION];
  logic [ADDR_W-1:0]    k_q    [PARTITION];
  logic [ADDR_W-1:0]    y_q    [PARTITION];
  logic [ADDR_W-1:0]    x_q    [PARTITION];
  logic [ADDR_W-1:0]    row_q  [PARTITION];
  logic [PARTITION-1:0] full_q, fin_q;
  logic                 mem_req_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [COLOR_W-1:0]   data_q;
  logic [LANE_W-1:0]    owner_q, last_q;

  logic                 run, enter_run, wr_done;
  logic                 gnt_vld;
  logic [LANE_W-1:0]    gnt_idx, cand;
  logic [COUNT_W-1:0]   gnt_cnt;
  logic [COLOR_W-1:0]   gnt_color;

  assign run       = (state_q == ST_RUN);
  assign enter_run = start && (state_q != ST_RUN);
  assign wr_done   = mem_req_q && mem_ack;
  assign in_ready  = {PARTITION{run}} & ~full_q & ~fin_q;

  // Round-robin search begins at the lane after the most recent grant.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 1; i <= PARTITION; i++) begin
      cand = LANE_W'((int'(last_q) + i) % PARTITION);
      if (!gnt_vld && full_q[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (!run || mem_req_q) gnt_vld = 1'b0;
  end

  assign gnt_cnt = cnt_q[gnt_idx];

  mandel_color_map #(.MAX_ITERATIONS(MAX_ITERATIONS)) u_color_map (
    .count_i (gnt_cnt),
    .color_o (gnt_color)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
      ST_RUN:           if ((&fin_q) && !(|full_q) && !mem_req_q) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      full_q    <= '0;
      fin_q     <= '0;
      mem_req_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      owner_q   <= '0;
      last_q    <= LANE_W'(PARTITION - 1);
      for (int p = 0; p < PARTITION; p++) begin
        cnt_q[p] <= '0;
        k_q[p]   <= '0;
        y_q[p]   <= '0;
        row_q[p] <= '0;
        x_q[p]   <= ADDR_W'(p);
      end
    end else begin
      state_q <= state_d;
      for (int p = 0; p < PARTITION; p++) begin
        if (enter_run) begin
          k_q[p]   <= '0;
          y_q[p]   <= '0;
          row_q[p] <= '0;
          x_q[p]   <= ADDR_W'(p);
          fin_q[p] <= 1'b0;
        end else if (wr_done && owner_q == LANE_W'(p)) begin
          full_q[p] <= 1'b0;
          if (k_q[p] == K_LAST) begin
            k_q[p] <= '0;
            x_q[p] <= ADDR_W'(p);
            if (y_q[p] == Y_LAST) begin
              fin_q[p] <= 1'b1;
            end else begin
              y_q[p]   <= y_q[p] + ONE;
              row_q[p] <= row_q[p] + W_STEP;
            end
          end else begin
            k_q[p] <= k_q[p] + ONE;
            x_q[p] <= x_q[p] + P_STEP;
          end
        end
        if (in_valid[p] && in_ready[p]) begin
          cnt_q[p]  <= in_count[p*COUNT_W +: COUNT_W];
          full_q[p] <= 1'b1;
        end
      end
      if (wr_done) begin
        mem_req_q <= 1'b0;
      end else if (gnt_vld) begin
        mem_req_q <= 1'b1;
        addr_q    <= row_q[gnt_idx] + x_q[gnt_idx];
        data_q    <= gnt_color;
        owner_q   <= gnt_idx;
        last_q    <= gnt_idx;
      end
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign done     = (state_q == ST_DONE);

`ifdef MANDEL_PERF_CNT_EN
  logic [31:0] cycles_q;

  always_ff @(posedge clk) begin
    if (reset || enter_run) begin
      cycles_q <= '0;
    end else if (run && cycles_q != '1) begin
      cycles_q <= cycles_q + 32'd1;
    end
  end

  assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_mandel_pixel_writer.sv
// Directed bench for mandel_pixel_writer on a 4x2 frame with two lanes.
module tb_mandel_pixel_writer;

  localparam int P  = 2;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 19;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [P-1:0]      in_valid = '0;
  logic [P*11-1:0]   in_count = '0;
  logic [P-1:0]      in_ready;
  logic              mem_req;
  logic [AW-1:0]     mem_addr;
  logic [7:0]        mem_data;
  logic              mem_ack = 1'b1;
  logic              done;
`ifdef MANDEL_PERF_CNT_EN
  logic [31:0]       cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] log_addr[$];
  logic [7:0]    log_data[$];

  mandel_pixel_writer #(
    .PARTITION(P), .MAX_ITERATIONS(100), .SCREEN_W(W), .SCREEN_H(H), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_count(in_count), .in_ready(in_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ack(mem_ack), .done(done)
`ifdef MANDEL_PERF_CNT_EN
    , .cycles(cycles)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && mem_req && mem_ack) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_data);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; start = 1'b0; in_valid = '0; in_count = '0; mem_ack = 1'b1;
    tick; tick;
    reset = 1'b0;
    log_addr.delete(); log_data.delete();
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 2'b11;
    tick; tick;
    n_checks++;
    if ({mem_req, mem_addr, mem_data, done} !== {1'b0, 19'd0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b addr=%0d data=%h done=%b, required all zero", mem_req, mem_addr, mem_data, done);
    end
    n_checks++;
    if (in_ready !== 2'b00) begin
      n_fail++; $display("FAIL reset_in_ready: got %b required 00", in_ready);
    end
    reset = 1'b0;
    tick; tick;
    n_checks++;
    if ({in_ready, mem_req, done} !== 4'b0000) begin
      n_fail++; $display("FAIL idle_no_accept: in_ready=%b req=%b done=%b required 0", in_ready, mem_req, done);
    end
`ifdef MANDEL_PERF_CNT_EN
    n_checks++;
    if (cycles !== 32'd0) begin
      n_fail++; $display("FAIL reset_cycles: got %0d required 0", cycles);
    end
`endif
    in_valid = '0;
  endtask

  task automatic test_single_pixel;
    do_reset;
    pulse_start;
    n_checks++;
    if (in_ready !== 2'b11) begin
      n_fail++; $display("FAIL single_ready_run: got %b required 11", in_ready);
    end
    in_valid = 2'b01; in_count[10:0] = 11'd5;
    tick;
    in_valid = 2'b00;
    n_checks++;
    if (mem_req !== 1'b0 || in_ready[0] !== 1'b0) begin
      n_fail++; $display("FAIL single_capture: req=%b rdy0=%b required 0 0", mem_req, in_ready[0]);
    end
    tick;
    n_checks++;
    if ({mem_req, mem_addr, mem_data} !== {1'b1, 19'd0, 8'hFA}) begin
      n_fail++; $display("FAIL single_write: req=%b addr=%0d data=%h required 1 0 fa", mem_req, mem_addr, mem_data);
    end
    tick;
    n_checks++;
    if (mem_req !== 1'b0 || in_ready[0] !== 1'b1) begin
      n_fail++; $display("FAIL single_after_ack: req=%b rdy0=%b required 0 1", mem_req, in_ready[0]);
    end
    n_checks++;
    if (log_addr.size() != 1) begin
      n_fail++; $display("FAIL single_write_count: got %0d required 1", log_addr.size());
    end
  endtask

  task automatic test_full_frame;
    int cseq [4];
    logic [7:0] exp_col [4];
    int idx [2];
    logic [P-1:0] fire;
    logic [7:0] seen;
    int n_run;
    bit got_done;
    cseq    = '{0, 100, 3, 99};
    exp_col = '{8'hFF, 8'h00, 8'hFC, 8'h9C};
    idx = '{0, 0};
    seen = '0; n_run = 0; got_done = 1'b0;
    do_reset;
    pulse_start;
    for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
      for (int p = 0; p < P; p++) begin
        if (idx[p] < 4) begin
          in_valid[p] = 1'b1;
          in_count[p*11 +: 11] = 11'(cseq[idx[p]]);
        end else begin
          in_valid[p] = 1'b0;
        end
      end
      @(negedge clk);
      fire = in_valid & in_ready;
      tick;
      n_run++;
      for (int p = 0; p < P; p++) if (fire[p]) idx[p]++;
      if (done) got_done = 1'b1;
    end
    in_valid = '0;
    n_checks++;
    if (!got_done) begin
      n_fail++; $display("FAIL frame_done: done never rose within 200 cycles");
    end
    n_checks++;
    if (log_addr.size() != 8) begin
      n_fail++; $display("FAIL frame_write_count: got %0d required 8", log_addr.size());
    end
    for (int i = 0; i < log_addr.size(); i++) begin
      n_checks++;
      if (log_addr[i] > 7 || log_data[i] !== exp_col[log_addr[i][2:1]]) begin
        n_fail++; $display("FAIL frame_pixel: addr=%0d data=%h", log_addr[i], log_data[i]);
      end else begin
        seen[log_addr[i][2:0]] = 1'b1;
      end
    end
    n_checks++;
    if (seen !== 8'hFF) begin
      n_fail++; $display("FAIL frame_coverage: addresses written mask=%b required 11111111", seen);
    end
    tick; tick;
    n_checks++;
    if (in_ready !== 2'b00 || done !== 1'b1) begin
      n_fail++; $display("FAIL frame_after_done: in_ready=%b done=%b required 00 1", in_ready, done);
    end
`ifdef MANDEL_PERF_CNT_EN
    n_checks++;
    if (cycles !== 32'(n_run)) begin
      n_fail++; $display("FAIL perf_run_cycles: got %0d required %0d", cycles, n_run);
    end
    tick; tick; tick;
    n_checks++;
    if (cycles !== 32'(n_run)) begin
      n_fail++; $display("FAIL perf_frozen: got %0d required %0d", cycles, n_run);
    end
    pulse_start;
    n_checks++;
    if (cycles !== 32'd0 || done !== 1'b0) begin
      n_fail++; $display("FAIL perf_restart: cycles=%0d done=%b required 0 0", cycles, done);
    end
`endif
  endtask

  task automatic test_round_robin;
    int hold;
    bit saw_both_full;
    logic [AW-1:0] exp_addr [4];
    exp_addr = '{19'd0, 19'd1, 19'd2, 19'd3};
    hold = 0; saw_both_full = 1'b0;
    do_reset;
    mem_ack = 1'b0;
    pulse_start;
    in_valid = 2'b11;
    in_count = {11'd2, 11'd1};
    for (int cyc = 0; cyc < 80 && log_addr.size() < 4; cyc++) begin
      hold = mem_req ? hold + 1 : 0;
      if (hold == 2 && in_ready == 2'b00) saw_both_full = 1'b1;
      mem_ack = (hold >= 3);
      tick;
    end
    in_valid = '0; mem_ack = 1'b1;
    n_checks++;
    if (!saw_both_full) begin
      n_fail++; $display("FAIL rr_contention: never saw both lanes full during a pending write");
    end
    n_checks++;
    if (log_addr.size() < 4) begin
      n_fail++; $display("FAIL rr_progress: got %0d writes required 4", log_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (log_addr[i] !== exp_addr[i]) begin
          n_fail++; $display("FAIL rr_order: write %0d addr=%0d required %0d", i, log_addr[i], exp_addr[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    mem_ack = 1'b0;
    pulse_start;
    in_valid = 2'b01; in_count[10:0] = 11'd7;
    tick;
    in_valid = 2'b00;
    tick;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({mem_req, mem_addr, mem_data, in_ready[0]} !== {1'b1, 19'd0, 8'hF8, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_stable cycle %0d: req=%b addr=%0d data=%h rdy0=%b required 1 0 f8 0", i, mem_req, mem_addr, mem_data, in_ready[0]);
      end
      tick;
    end
    mem_ack = 1'b1;
    tick;
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: req=%b required 0", mem_req);
    end
    tick; tick;
    n_checks++;
    if (log_addr.size() != 1) begin
      n_fail++; $display("FAIL bp_once: got %0d writes required 1", log_addr.size());
    end
    in_valid = 2'b01; in_count[10:0] = 11'd7;
    tick;
    in_valid = 2'b00;
    tick;
    n_checks++;
    if ({mem_req, mem_addr} !== {1'b1, 19'd2}) begin
      n_fail++; $display("FAIL bp_next_addr: req=%b addr=%0d required 1 2", mem_req, mem_addr);
    end
    tick;
  endtask

  task automatic test_reset_mid_frame;
    do_reset;
    mem_ack = 1'b0;
    pulse_start;
    in_valid = 2'b01; in_count[10:0] = 11'd5;
    tick;
    in_valid = 2'b00;
    tick;
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre: req=%b required 1", mem_req);
    end
    reset = 1'b1;
    tick;
    n_checks++;
    if ({mem_req, done, in_ready} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_mid: req=%b done=%b in_ready=%b required 0", mem_req, done, in_ready);
    end
    reset = 1'b0;
    mem_ack = 1'b1;
    tick;
    pulse_start;
    in_valid = 2'b01; in_count[10:0] = 11'd10;
    tick;
    in_valid = 2'b00;
    tick;
    n_checks++;
    if ({mem_req, mem_addr, mem_data} !== {1'b1, 19'd0, 8'hF5}) begin
      n_fail++; $display("FAIL rst_restart: req=%b addr=%0d data=%h required 1 0 f5", mem_req, mem_addr, mem_data);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_single_pixel;
    test_full_frame;
    test_round_robin;
    test_backpressure;
    test_reset_mid_frame;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
